astrocade_autotype: RTL and testbench
=====================================

# astrocade_autotype

Keystroke sequencer that drives the Astrocade keypad matrix from a byte stream, so the core can type Bally BASIC listings or scripted key sequences without a user. It buffers key codes in a small FIFO and presses each key for a fixed number of timing ticks, then releases it for a fixed gap. Its `row_data` is OR-ed with the live keyboard/joystick matrix output at the column-read port, so it shares the matrix with user input rather than replacing it.

## Interface
Parameters:
- `FIFO_DEPTH`, default 8: entries in the key-code FIFO. Must be a power of 2 and at least 2.
- `HOLD_TICKS`, default 3: number of `tick` pulses a key stays pressed. Minimum 1.
- `GAP_TICKS`, default 2: number of `tick` pulses of release after each key. Minimum 1.

Ports:
- `clk_sys` in 1: system clock.
- `reset` in 1: reset. One clock; reset is synchronous and active-high.
- `tick` in 1: timing strobe (one `clk_sys` wide), normally the frame/vblank pulse.
- `abort` in 1: synchronous flush of FIFO and sequencer.
- `in_valid` in 1: key code offered.
- `in_data` in 8: key code `{col[3:0], row[3:0]}`. The value 8'hFF is a pause marker.
- `in_ready` out 1: FIFO can accept a byte this cycle.
- `col_select` in 8: one-hot matrix column being read.
- `row_data` out 8: injected row bits for the selected column. Combinational.
- `busy` out 1: FIFO is non-empty or the state is not IDLE.
- `active_code` out 8: code currently being held. 8'h00 when no key is held.

## Operation
- **Push**
  - A push occurs when `in_valid & in_ready`.
  - `in_ready = !full`. It does not look ahead to a same-cycle pop.
  - A code is accepted only if it is 8'hFF, or if col ≤ 7 and row ≤ 7.
  - Any other code is handshaken but discarded. It does not occupy an entry.
- **FIFO**
  - Circular buffer with read and write pointers one bit wider than the address.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - full = address bits equal and MSBs differ. empty = pointers equal.
  - A simultaneous push and pop is legal whenever the FIFO is neither empty nor full.
- **State machine**
  - IDLE: if the FIFO is not empty, pop the head into `cur`, load `cnt = HOLD_TICKS`, and go to PRESS.
  - PRESS: on `tick`, decrement `cnt`. On the tick where `cnt == 1`, load `cnt = GAP_TICKS` and go to GAP.
  - GAP: same rule as PRESS. On the tick where `cnt == 1`, go to IDLE.
  - A pause marker (`cur == 8'hFF`) runs through PRESS and GAP with nothing pressed.
- **Outputs**
  - Key held: state == PRESS and `cur != 8'hFF`.
  - `row_data`: when a key is held and `col_select == (8'h01 << cur[6:4])`, output `8'h01 << cur[2:0]`. Otherwise 8'h00.
  - A zero or multi-hot `col_select` always gives `row_data` = 8'h00.
  - `active_code` = `cur` while a key is held, else 8'h00.
- **abort**
  - Clears both pointers, goes to IDLE, sets `cur = 8'h00` and `cnt = 0`.
  - Takes priority over any push or pop in the same cycle.
  - Any push offered in that cycle is dropped, although `in_ready` may read 1.
- **reset**: same effect as `abort`.

## Timing
- Reset values: `in_ready` = 1, `busy` = 0, `row_data` = 8'h00, `active_code` = 8'h00, state = IDLE, FIFO empty.
- Push at cycle N into an empty, idle block:
  - Pop and PRESS entry at N+1.
  - `row_data` and `active_code` valid from N+2.
  - `busy` is 1 from N+1. `busy` is registered from the next-state values.
- PRESS lasts from entry until the cycle after the `HOLD_TICKS`-th tick seen in PRESS. A tick coinciding with the entry cycle is not counted.
- Release is visible the cycle after the final hold tick. GAP timing follows the same rule.
- After the last GAP tick, IDLE lasts one cycle. The next pop happens in that cycle if the FIFO is non-empty.
- `busy` falls the cycle after GAP→IDLE when the FIFO is empty.
- `tick` arriving while IDLE is ignored.
- With the FIFO full, `in_ready` returns to 1 the cycle after the pop.

## Test plan
- **Single key**
  - Stimulus: after reset, push 8'h74; pulse `tick` every 100 cycles.
  - Required: with `col_select` = 8'h80, `row_data` = 8'h10 for exactly 3 ticks.
  - Required: `row_data` = 8'h00 for any other column.
  - Required: then 2 ticks of release, then `busy` = 0.
- **Pause and invalid**
  - Stimulus: push 8'h62, 8'hFF, 8'h88, 8'h52.
  - Required: 8'h88 is handshaken but dropped.
  - Required: key 8 is pressed, then 5 ticks with no key, then key 9.
  - Required: total of 3 key-equivalent slots (15 ticks) before `busy` = 0.
- **Full FIFO**
  - Stimulus: hold `tick` low and push 9 codes back-to-back.
  - Required: the first is popped, 8 more fill the FIFO, and `in_ready` = 0 thereafter.
  - Required: after the first key finishes, `in_ready` = 1 one cycle after the next pop.
  - Required: all 9 codes emerge in order.
- **Wrap-around**
  - Stimulus: stream 20 codes while respecting `in_ready`.
  - Required: the `active_code` sequence exactly matches the input order across pointer wrap.
- **Abort mid-press**
  - Stimulus: assert `abort` during PRESS with 4 codes queued and `in_valid` high.
  - Required: next cycle `row_data` = 8'h00, `active_code` = 8'h00, `busy` = 0, FIFO empty.
  - Required: the code offered in the abort cycle is lost.
- **Tick on entry**
  - Stimulus: push so that PRESS entry coincides with a `tick`.
  - Required: the key is still held for 3 subsequent ticks.
  - Required: reset asserted mid-GAP returns all outputs to reset values on the next cycle.

Source files
------------

// File: rtl/astrocade_autotype.sv
// Keystroke sequencer for the Astrocade keypad matrix: queues key codes and
// presses each one for HOLD_TICKS ticks, then releases it for GAP_TICKS ticks.
module astrocade_autotype #(
    parameter int FIFO_DEPTH = 8,
    parameter int HOLD_TICKS = 3,
    parameter int GAP_TICKS  = 2
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       tick,
    input  logic       abort,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    input  logic [7:0] col_select,
    output logic [7:0] row_data,
    output logic       busy,
    output logic [7:0] active_code
);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CNT_MAX = (HOLD_TICKS > GAP_TICKS) ? HOLD_TICKS : GAP_TICKS;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] HOLD_C  = CW'(HOLD_TICKS);
    localparam logic [CW-1:0] GAP_C   = CW'(GAP_TICKS);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

    state_t        state_q, state_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [7:0]    cur_q, cur_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic [7:0]    mem_q [FIFO_DEPTH];

    logic       full, empty, code_ok, push, pop, held;
    logic [7:0] col_mask;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign in_ready = !full;

    // Only codes addressing the 8x8 matrix (or the pause marker) take an entry;
    // anything else is still handshaken so the source never stalls on it.
    assign code_ok = (in_data == 8'hFF) || (!in_data[7] && !in_data[3]);
    assign push    = in_valid && in_ready && code_ok && !abort;
    assign pop     = (state_q == IDLE) && !empty && !abort;

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        cnt_d    = cnt_q;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    cur_d   = mem_q[rd_ptr_q[AW-1:0]];
                    cnt_d   = HOLD_C;
                    state_d = PRESS;
                end
            end
            PRESS: begin
                if (tick) begin
                    if (cnt_q == CNT_ONE) begin
                        cnt_d   = GAP_C;
                        state_d = GAP;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d  = IDLE;
            cur_d    = 8'h00;
            cnt_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
        busy_d = (wr_ptr_d != rd_ptr_d) || (state_d != IDLE);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q  <= IDLE;
            cur_q    <= 8'h00;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            busy_q   <= busy_d;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= in_data;
    end

    // A pause marker walks through PRESS/GAP without touching the matrix.
    assign held        = (state_q == PRESS) && (cur_q != 8'hFF);
    assign col_mask    = 8'h01 << cur_q[6:4];
    assign row_data    = (held && (col_select == col_mask)) ? (8'h01 << cur_q[2:0]) : 8'h00;
    assign active_code = held ? cur_q : 8'h00;
    assign busy        = busy_q;

endmodule

// File: tb/tb_astrocade_autotype.sv
// Bench for astrocade_autotype: table of single-key vectors, directed corner
// sequences, and randomized streams checked against a key-order scoreboard.
module tb_astrocade_autotype;
    localparam int HOLD = 3;
    localparam int GAPT = 2;

    typedef struct {
        logic [7:0] code;
        logic [7:0] col;
        logic [7:0] row;
        logic [7:0] act;
        logic       bsy;
    } vec_t;

    logic       clk_sys = 1'b0;
    logic       reset, tick, abort, in_valid, in_ready, busy;
    logic [7:0] in_data, col_select, row_data, active_code;

    astrocade_autotype #(.FIFO_DEPTH(8), .HOLD_TICKS(HOLD), .GAP_TICKS(GAPT)) dut (
        .clk_sys(clk_sys), .reset(reset), .tick(tick), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .col_select(col_select), .row_data(row_data), .busy(busy),
        .active_code(active_code)
    );

    always #5 clk_sys = ~clk_sys;

    int total = 0, bad = 0;
    int cyc_cnt, tick_per;
    bit mon_en, rand_col, prev_held, ep_known;
    logic [7:0] q[$];
    logic [7:0] cur_exp;
    int ticks_in, last_hold, idle_ticks, gap_before, busy_ticks, episodes;
    logic s_ready, s_busy, s_hs;
    logic [7:0] s_row, s_active;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_row(input logic [7:0] code, input logic [7:0] col);
        logic [7:0] r;
        r = 8'h00;
        if ($countones(col) == 1 && col[code[6:4]]) r[code[2:0]] = 1'b1;
        return r;
    endfunction

    function automatic bit code_ok(input logic [7:0] c);
        return (c == 8'hFF) || (c[7:4] <= 4'd7 && c[3:0] <= 4'd7);
    endfunction

    function automatic logic [7:0] gen_code();
        int r;
        logic [7:0] c;
        r = $urandom_range(0, 9);
        if (r == 0) c = 8'hFF;
        else if (r == 1) c = 8'h80 | 8'($urandom_range(0, 127));
        else if (r == 2) c = {1'b0, 3'($urandom_range(0, 7)), 1'b1, 3'($urandom_range(0, 7))};
        else begin
            c = {1'b0, 3'($urandom_range(0, 7)), 1'b0, 3'($urandom_range(0, 7))};
            if (c == 8'h00) c = 8'h11;
        end
        return c;
    endfunction

    // One clock: drive, sample at negedge, update scoreboard, step past posedge.
    task automatic cyc();
        logic held;
        if (tick_per > 0) tick = ((cyc_cnt % tick_per) == tick_per - 1);
        if (rand_col) col_select = ($urandom_range(0, 3) != 0) ? (8'h01 << $urandom_range(0, 7)) : 8'($urandom);
        @(negedge clk_sys);
        s_ready  = in_ready;
        s_busy   = busy;
        s_row    = row_data;
        s_active = active_code;
        s_hs     = in_valid && in_ready;
        held     = (active_code != 8'h00);
        if (mon_en) begin
            if (held && !prev_held) begin
                while (q.size() > 0 && q[0] == 8'hFF) void'(q.pop_front());
                if (q.size() == 0) begin
                    chk("key_unexpected", active_code, 8'h00);
                    ep_known = 0;
                end else begin
                    cur_exp = q.pop_front();
                    chk("key_order", active_code, cur_exp);
                    ep_known = 1;
                end
                ticks_in   = 0;
                gap_before = idle_ticks;
                idle_ticks = 0;
                episodes++;
            end
            if (held) begin
                if (ep_known) chk("row_data", row_data, exp_row(cur_exp, col_select));
                if (tick) ticks_in++;
            end else if (busy && tick) idle_ticks++;
            if (!held && prev_held) begin
                last_hold = ticks_in;
                chk("hold_ticks", ticks_in, HOLD);
            end
        end
        prev_held = held;
        if (busy && tick) busy_ticks++;
        if (!abort && !reset && s_hs && code_ok(in_data)) q.push_back(in_data);
        if (abort || reset) begin
            q.delete();
            prev_held = 0;
        end
        @(posedge clk_sys);
        #1;
        cyc_cnt++;
    endtask

    task automatic push1(input logic [7:0] code);
        in_valid = 1'b1;
        in_data  = code;
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int bound, input string name);
        for (int i = 0; i < bound; i++) begin
            cyc();
            if (!s_busy) break;
        end
        chk(name, s_busy, 1'b0);
    endtask

    initial begin
        vec_t tbl[12];
        logic [7:0] fc[9];
        int pt, n, g, left, ep0;

        tbl[0]  = '{8'h74, 8'h80, 8'h10, 8'h74, 1'b1};
        tbl[1]  = '{8'h74, 8'h40, 8'h00, 8'h74, 1'b1};
        tbl[2]  = '{8'h74, 8'h00, 8'h00, 8'h74, 1'b1};
        tbl[3]  = '{8'h74, 8'hC0, 8'h00, 8'h74, 1'b1};
        tbl[4]  = '{8'h00, 8'h01, 8'h01, 8'h00, 1'b1};
        tbl[5]  = '{8'h07, 8'h01, 8'h80, 8'h07, 1'b1};
        tbl[6]  = '{8'h70, 8'h80, 8'h01, 8'h70, 1'b1};
        tbl[7]  = '{8'h35, 8'h08, 8'h20, 8'h35, 1'b1};
        tbl[8]  = '{8'h35, 8'h18, 8'h00, 8'h35, 1'b1};
        tbl[9]  = '{8'hFF, 8'h01, 8'h00, 8'h00, 1'b1};
        tbl[10] = '{8'h88, 8'h01, 8'h00, 8'h00, 1'b0};
        tbl[11] = '{8'h5F, 8'h20, 8'h00, 8'h00, 1'b0};
        fc = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h21, 8'h22};

        reset = 1; tick = 0; abort = 0; in_valid = 0; in_data = 0; col_select = 8'h01;
        cyc_cnt = 0; tick_per = 0; mon_en = 0; rand_col = 0; prev_held = 0; ep_known = 0;
        ticks_in = 0; last_hold = 0; idle_ticks = 0; gap_before = 0; busy_ticks = 0; episodes = 0;
        cur_exp = 8'h00;

        // reset state
        cyc(); cyc(); reset = 0; cyc();
        chk("rst_in_ready", s_ready, 1'b1);
        chk("rst_busy", s_busy, 1'b0);
        chk("rst_row", s_row, 8'h00);
        chk("rst_active", s_active, 8'h00);

        // table: one key each, latency and column decode
        foreach (tbl[i]) begin
            abort = 1; cyc(); abort = 0;
            col_select = tbl[i].col;
            push1(tbl[i].code);
            cyc();
            chk("tbl_busy_n1", s_busy, tbl[i].bsy);
            chk("tbl_row_n1", s_row, 8'h00);
            cyc();
            chk("tbl_row", s_row, tbl[i].row);
            chk("tbl_active", s_active, tbl[i].act);
        end
        abort = 1; cyc(); abort = 0;

        // single key, tick every 100 cycles
        mon_en = 1; prev_held = 0; tick_per = 100; cyc_cnt = 0; busy_ticks = 0; pt = 0;
        col_select = 8'h80;
        push1(8'h74);
        for (int i = 0; i < 1000; i++) begin
            col_select = (cyc_cnt % 2 == 1) ? 8'h80 : 8'h40;
            cyc();
            if (tick && s_row == 8'h10) pt++;
            if (i > 2 && !s_busy) break;
        end
        chk("single_press_ticks", pt, 3);
        chk("single_busy_ticks", busy_ticks, 5);
        chk("single_idle", s_busy, 1'b0);

        // pause marker and invalid code
        tick_per = 10; cyc_cnt = 0; busy_ticks = 0; idle_ticks = 0; episodes = 0;
        col_select = 8'h40;
        push1(8'h62); push1(8'hFF);
        push1(8'h88); chk("invalid_handshake", s_ready, 1'b1);
        push1(8'h52);
        wait_idle(500, "pause_timeout");
        chk("pause_episodes", episodes, 2);
        chk("pause_gap_ticks", gap_before, 7);
        chk("pause_busy_ticks", busy_ticks, 15);

        // full FIFO, ticks held low
        tick_per = 0; tick = 0; episodes = 0; rand_col = 1;
        foreach (fc[i]) begin
            push1(fc[i]);
            chk("full_push_ready", s_ready, 1'b1);
        end
        in_valid = 1; in_data = 8'h23;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("full_not_ready", s_ready, 1'b0);
        end
        for (int k = 0; k < HOLD + GAPT; k++) begin
            tick = 1; cyc(); tick = 0;
            if (k < HOLD + GAPT - 1) begin cyc(); cyc(); end
        end
        cyc(); chk("full_pop_cycle_ready", s_ready, 1'b0);
        cyc(); chk("full_after_pop_ready", s_ready, 1'b1);
        in_valid = 0;
        cyc(); chk("full_again", s_ready, 1'b0);
        tick_per = 4;
        wait_idle(3000, "full_timeout");
        chk("full_episodes", episodes, 10);
        chk("full_queue_left", q.size(), 0);
        rand_col = 0;

        // abort mid-press with codes queued and a push offered
        tick_per = 0; tick = 0; col_select = 8'h10; episodes = 0;
        push1(8'h41); push1(8'h42); push1(8'h43); push1(8'h44); push1(8'h45);
        cyc();
        chk("abort_pre_active", s_active, 8'h41);
        abort = 1; in_valid = 1; in_data = 8'h33;
        cyc();
        abort = 0; in_valid = 0;
        cyc();
        chk("abort_row", s_row, 8'h00);
        chk("abort_active", s_active, 8'h00);
        chk("abort_busy", s_busy, 1'b0);
        chk("abort_ready", s_ready, 1'b1);
        ep0 = episodes;
        tick_per = 3;
        for (int i = 0; i < 40; i++) cyc();
        chk("abort_stays_idle", s_busy, 1'b0);
        chk("abort_no_more_keys", episodes, ep0);

        // tick on PRESS entry, then reset mid-GAP
        tick_per = 0; tick = 0; col_select = 8'h80;
        push1(8'h74);
        tick = 1; cyc(); tick = 0;
        chk("entry_active_n1", s_active, 8'h00);
        push1(8'h35);
        for (int k = 0; k < HOLD; k++) begin
            cyc(); tick = 1; cyc(); tick = 0;
        end
        cyc();
        chk("entry_released", s_active, 8'h00);
        chk("entry_hold", last_hold, HOLD);
        tick = 1; cyc(); tick = 0; cyc();
        reset = 1; in_valid = 1; in_data = 8'h36;
        cyc();
        reset = 0; in_valid = 0;
        cyc();
        chk("rst2_in_ready", s_ready, 1'b1);
        chk("rst2_busy", s_busy, 1'b0);
        chk("rst2_row", s_row, 8'h00);
        chk("rst2_active", s_active, 8'h00);
        tick_per = 3; ep0 = episodes;
        for (int i = 0; i < 30; i++) cyc();
        chk("rst2_stays_idle", s_busy, 1'b0);
        chk("rst2_no_keys", episodes, ep0);

        // randomized streams across pointer wrap
        rand_col = 1;
        for (int round = 0; round < 3; round++) begin
            tick_per = 3 + round; n = 0; g = 0;
            while (n < 20 && g < 3000) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = gen_code();
                cyc();
                if (s_hs) n++;
                g++;
            end
            in_valid = 0;
            chk("rand_pushes", n, 20);
            wait_idle(3000, "rand_timeout");
            left = 0;
            foreach (q[j]) if (q[j] != 8'hFF) left++;
            chk("rand_drain", left, 0);
            q.delete();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
